// File: rtl/div_16_seq_pkg.sv
// Shared definitions for the sequential 16-bit divider: state encoding and default width.
package div_16_seq_pkg;

  localparam int DIV_WIDTH = 16;

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_CALC_ENC = 2'd1;
  localparam logic [1:0] ST_FIX_ENC  = 2'd2;
  localparam logic [1:0] ST_DONE_ENC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_CALC = ST_CALC_ENC,
    ST_FIX  = ST_FIX_ENC,
    ST_DONE = ST_DONE_ENC
  } div_state_e;

endpackage

// File: rtl/div_16_seq_if.sv
// Request/result bundle between the ALU-side requester and the divider.
interface div_16_seq_if
  import div_16_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);
  logic             Start;
  logic             Signed_Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             Div_Zero;

  modport master (
    output Start, Signed_Op, A, B,
    input  Busy, Done, Q, R, Div_Zero
  );

  modport slave (
    input  Start, Signed_Op, A, B,
    output Busy, Done, Q, R, Div_Zero
  );
endinterface

// File: rtl/div_16_seq_step.sv
// One restoring-division iteration: shift {rem,quo} left and try to subtract the divisor.
module div_16_seq_step
  import div_16_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] trial;
  logic [WIDTH:0]   rem_wide;
  logic             unused_msb;

  // rem < divisor on entry, so the kept remainder always fits back in WIDTH bits
  always_comb begin
    rem_sh   = {rem_i, quo_i[WIDTH-1]};
    trial    = {1'b0, rem_sh} - {2'b00, dvs_i};
    rem_wide = trial[WIDTH+1] ? rem_sh : trial[WIDTH:0];
  end

  assign rem_o      = rem_wide[WIDTH-1:0];
  assign quo_o      = {quo_i[WIDTH-2:0], ~trial[WIDTH+1]};
  assign unused_msb = rem_wide[WIDTH];

endmodule

// File: rtl/div_16_seq.sv
// Iterative signed/unsigned divider: one restoring step per clock, sign fixup, held results.
//
//   state | meaning
//   IDLE  | waiting for Start; results from the last operation held
//   CALC  | one quotient bit per cycle, WIDTH cycles
//   FIX   | apply result signs and load Q/R
//   DONE  | single-cycle Done pulse, then back to IDLE
module div_16_seq
  import div_16_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic         clk,
  input logic         rst_n,
  div_16_seq_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] res_q_q, res_q_d;
  logic [WIDTH-1:0] res_r_q, res_r_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  div_16_seq_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  // |0x8000| stays 0x8000 and is then treated as an unsigned magnitude
  always_comb begin
    sign_a = bus.Signed_Op & bus.A[WIDTH-1];
    sign_b = bus.Signed_Op & bus.B[WIDTH-1];
    mag_a  = sign_a ? (~bus.A + WIDTH'(1)) : bus.A;
    mag_b  = sign_b ? (~bus.B + WIDTH'(1)) : bus.B;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    res_q_d   = res_q_q;
    res_r_d   = res_r_q;
    dz_d      = dz_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.Start) begin
          if (bus.B == '0) begin
            res_q_d = '1;
            res_r_d = bus.A;
            dz_d    = 1'b1;
            state_d = ST_DONE;
          end else begin
            rem_d     = '0;
            quo_d     = mag_a;
            dvs_d     = mag_b;
            neg_quo_d = sign_a ^ sign_b;
            neg_rem_d = sign_a;
            cnt_d     = CW'(WIDTH - 1);
            state_d   = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        if (cnt_q == '0) begin
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_FIX: begin
        res_q_d = neg_quo_q ? (~quo_q + WIDTH'(1)) : quo_q;
        res_r_d = neg_rem_q ? (~rem_q + WIDTH'(1)) : rem_q;
        dz_d    = 1'b0;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_CALC) || (state_d == ST_FIX);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      res_q_q   <= '0;
      res_r_q   <= '0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      res_q_q   <= res_q_d;
      res_r_q   <= res_r_d;
      dz_q      <= dz_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;
  assign bus.Q        = res_q_q;
  assign bus.R        = res_r_q;
  assign bus.Div_Zero = dz_q;

endmodule

// File: tb/tb_div_16_seq.sv
// Directed and random checks of div_16_seq against an integer-arithmetic reference.
module tb_div_16_seq;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  div_16_seq_if #(.WIDTH(16)) bus ();

  div_16_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division; SV int '/' and '%' truncate toward zero.
  function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic s,
                                output logic [15:0] q, output logic [15:0] r, output logic dz);
    int sa, sb, qi, ri;
    if (b == 16'h0) begin
      q = 16'hFFFF; r = a; dz = 1'b1;
    end else if (s) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      qi = sa / sb;
      ri = sa % sb;
      q  = qi[15:0];
      r  = ri[15:0];
      dz = 1'b0;
    end else begin
      q = a / b; r = a % b; dz = 1'b0;
    end
  endfunction

  // Issue one divide; poke>0 re-pulses Start with junk operands in that busy cycle.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input int poke);
    logic [15:0] eq, er, pq, pr;
    logic        edz;
    logic        busy_ok, hold_ok;
    int          cyc, exp_lat;
    model(a, b, s, eq, er, edz);
    exp_lat = (b == 16'h0) ? 1 : 18;
    pq = bus.Q;
    pr = bus.R;
    bus.A = a; bus.B = b; bus.Signed_Op = s; bus.Start = 1'b1;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    bus.A = 16'h0; bus.B = 16'h0;
    cyc = 1;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    while (bus.Done !== 1'b1 && cyc < 40) begin
      busy_ok &= (bus.Busy === 1'b1);
      hold_ok &= (bus.Q === pq) && (bus.R === pr);
      if (cyc == poke) begin
        bus.Start = 1'b1;
        bus.A = 16'($urandom);
        bus.B = 16'($urandom);
        bus.Signed_Op = ~s;
      end else begin
        bus.Start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.Start = 1'b0;
    chk({tag, " latency"}, cyc, exp_lat);
    chk({tag, " busy"}, busy_ok, 1'b1);
    chk({tag, " hold"}, hold_ok, 1'b1);
    chk({tag, " busy_at_done"}, bus.Busy, 1'b0);
    chk({tag, " Q"}, bus.Q, eq);
    chk({tag, " R"}, bus.R, er);
    chk({tag, " Div_Zero"}, bus.Div_Zero, edz);
    @(posedge clk); #1;
    chk({tag, " done_pulse"}, bus.Done, 1'b0);
    chk({tag, " Q_held"}, bus.Q, eq);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rs;
    int          cyc;
    logic        no_done;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.Start = 1'b0; bus.Signed_Op = 1'b0; bus.A = 16'h0; bus.B = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset outs", {bus.Busy, bus.Done, bus.Div_Zero, bus.Q, bus.R}, 35'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("u100_7", 16'd100, 16'd7, 1'b0, 0);
    run_op("uFFFF_1", 16'hFFFF, 16'h0001, 1'b0, 0);
    run_op("u5_9", 16'd5, 16'd9, 1'b0, 0);
    run_op("s-7_2", 16'hFFF9, 16'h0002, 1'b1, 0);
    run_op("s7_-2", 16'h0007, 16'hFFFE, 1'b1, 0);
    run_op("dz", 16'h1234, 16'h0000, 1'b0, 0);
    run_op("after_dz", 16'd1000, 16'd10, 1'b0, 0);
    run_op("s_ovf", 16'h8000, 16'hFFFF, 1'b1, 0);
    run_op("u8000_3", 16'h8000, 16'h0003, 1'b0, 0);
    run_op("ignore_start", 16'd12345, 16'd77, 1'b0, 5);
    run_op("dz_signed", 16'h8001, 16'h0000, 1'b1, 0);

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = 16'h0;
        1, 2:    rb = 16'($urandom_range(1, 20));
        3:       rb = 16'hFFFF - 16'($urandom_range(0, 20));
        default: rb = 16'($urandom);
      endcase
      rs = 1'($urandom_range(0, 1));
      run_op("rand", ra, rb, rs, 0);
    end

    // Abort mid-operation with an asynchronous reset.
    bus.A = 16'd999; bus.B = 16'd13; bus.Signed_Op = 1'b0; bus.Start = 1'b1;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    cyc = 1;
    while (cyc < 9) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("abort busy_before", bus.Busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort outs", {bus.Busy, bus.Done, bus.Div_Zero, bus.Q, bus.R}, 35'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    no_done = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      no_done &= (bus.Done === 1'b0) && (bus.Busy === 1'b0);
    end
    chk("abort no_done", no_done, 1'b1);
    chk("abort QR", {bus.Q, bus.R}, 32'h0);

    run_op("post_abort", 16'd100, 16'd7, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
